// File: rtl/usart_rx.sv
// usart_rx: asynchronous serial receiver. Frame is idle-high, one start bit,
// DATA_BITS data bits LSB first, one stop bit, timed by a clock-count bit timer.
// Optional feature macro: USART_RX_PARITY_EN adds an even-parity bit after the
// data bits and drives PARITY_ERR; when undefined PARITY_ERR is tied to 0.
`timescale 1ns/1ps
module usart_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef USART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t               state, state_next;
  logic                 sync1, rxs;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_end;

  // Control strobes decoded from the current state.
  logic busy, cnt_clr, sample_data, good_stop, bad_stop;
`ifdef USART_RX_PARITY_EN
  logic sample_par, parity_bit;
`endif

  assign bit_end = (bit_cnt == CNT_END);

  // Two-flop synchronizer on RX; rxs is the only view of the line used below.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= RX;
      rxs   <= sync1;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rxs) state_next = START;
      START:     if (bit_cnt == CNT_MID) state_next = rxs ? IDLE : DATA;
`ifdef USART_RX_PARITY_EN
      DATA:      if (bit_end && idx == IDX_LAST) state_next = PARITY;
      PARITY:    if (bit_end) state_next = STOP;
`else
      DATA:      if (bit_end && idx == IDX_LAST) state_next = STOP;
`endif
      STOP:      if (bit_end) state_next = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output / control decode: BUSY plus the datapath enables for this cycle.
  always_comb begin
    busy        = 1'b1;
    cnt_clr     = 1'b0;
    sample_data = 1'b0;
    good_stop   = 1'b0;
    bad_stop    = 1'b0;
`ifdef USART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy    = 1'b0;
        cnt_clr = 1'b1;
      end
      START:  cnt_clr = (bit_cnt == CNT_MID);
      DATA: begin
        cnt_clr     = bit_end;
        sample_data = bit_end;
      end
`ifdef USART_RX_PARITY_EN
      PARITY: begin
        cnt_clr    = bit_end;
        sample_par = bit_end;
      end
`endif
      STOP: begin
        cnt_clr   = bit_end;
        good_stop = bit_end && rxs;
        bad_stop  = bit_end && !rxs;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit timer, data index and shift register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt <= '0;
      idx     <= '0;
      shift   <= '0;
    end else begin
      bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;
      if (state != DATA)
        idx <= '0;
      else if (sample_data && idx != IDX_LAST)
        idx <= idx + 1'b1;
      // Right shift: the first data bit on the wire ends up in bit 0.
      if (sample_data)
        shift <= {rxs, shift[DATA_BITS-1:1]};
    end
  end

`ifdef USART_RX_PARITY_EN
  // Captured parity bit, sampled mid-bit like data.
  always_ff @(posedge CLK) begin
    if (RESET)           parity_bit <= 1'b0;
    else if (sample_par) parity_bit <= rxs;
  end
`endif

  // Registered outputs: strobes fire the cycle after the stop-bit sample.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      DATA_VALID <= good_stop;
      FRAME_ERR  <= bad_stop;
      if (good_stop) DATA_OUT <= shift;
    end
  end

`ifdef USART_RX_PARITY_EN
  // Even parity: data bits XOR parity bit must be 0; framing errors suppress it.
  always_ff @(posedge CLK) begin
    if (RESET) PARITY_ERR <= 1'b0;
    else       PARITY_ERR <= good_stop && ((^shift) ^ parity_bit);
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign BUSY = busy;

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed self-checking bench for usart_rx.
// Honours USART_RX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_usart_rx;

  localparam int CPB = 8;
  localparam int DB  = 8;
`ifdef USART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 2 + CPB / 2 + (DB + 1 + PB) * CPB + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid, frame_err, parity_err, busy;

  usart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .CLK(clk), .RESET(reset), .RX(rx),
    .DATA_OUT(data_out), .DATA_VALID(data_valid), .FRAME_ERR(frame_err),
    .PARITY_ERR(parity_err), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state, sampled on the falling edge.
  int            cycle_cnt = 0;
  int            valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, busy_cnt = 0;
  int            overlap_cnt = 0, vp_cnt = 0, last_valid_cycle = 0;
  logic [DB-1:0] rx_q[$];

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      valid_cnt++;
      rx_q.push_back(data_out);
      last_valid_cycle = cycle_cnt;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (data_valid === 1'b1 && frame_err === 1'b1) overlap_cnt++;
    if (data_valid === 1'b1 && parity_err === 1'b1) vp_cnt++;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Whole frame; par_flip inverts the even-parity bit when parity is built in.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                            input logic par_flip, output int start_cycle);
    start_cycle = cycle_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef USART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    int v0, f0, b0;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", data_out); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid got %b want 0", data_valid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else n_pass++;
    n_checks++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err got %b want 0", parity_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    idle(200);
    n_checks++; if (busy_cnt - b0 != 0) $display("FAIL idle_busy got %0d busy cycles want 0", busy_cnt - b0); else n_pass++;
    n_checks++; if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0)
      $display("FAIL idle_strobes got valid=%0d ferr=%0d want 0/0", valid_cnt - v0, ferr_cnt - f0); else n_pass++;
  endtask

  task automatic test_good_frame;
    int v0, f0, p0, sc, lat;
    v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, sc);
    idle(2 * CPB);
    lat = last_valid_cycle - sc;
    n_checks++; if (valid_cnt - v0 != 1) $display("FAIL a5_valid_pulses got %0d want 1", valid_cnt - v0); else n_pass++;
    n_checks++; if (data_out !== 8'hA5) $display("FAIL a5_data_out got %h want a5", data_out); else n_pass++;
    n_checks++; if (ferr_cnt - f0 != 0) $display("FAIL a5_frame_err got %0d want 0", ferr_cnt - f0); else n_pass++;
    n_checks++; if (perr_cnt - p0 != 0) $display("FAIL a5_parity_err got %0d want 0", perr_cnt - p0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL a5_busy_after got %b want 0", busy); else n_pass++;
    n_checks++; if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL a5_latency got %0d want %0d+-1", lat, LAT); else n_pass++;
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * CPB);
    n_checks++; if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0)
      $display("FAIL glitch_strobes got valid=%0d ferr=%0d want 0/0", valid_cnt - v0, ferr_cnt - f0); else n_pass++;
    n_checks++; if (data_out !== 8'hA5) $display("FAIL glitch_data_out got %h want a5", data_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_frame_error;
    int v0, f0, sc;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, sc);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    idle(2 * CPB);
    n_checks++; if (ferr_cnt - f0 != 1) $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0); else n_pass++;
    n_checks++; if (valid_cnt - v0 != 0) $display("FAIL ferr_no_valid got %0d want 0", valid_cnt - v0); else n_pass++;
    n_checks++; if (data_out !== 8'hA5) $display("FAIL ferr_data_held got %h want a5", data_out); else n_pass++;
    send_frame(8'h5A, 1'b1, 1'b0, sc);
    idle(2 * CPB);
    n_checks++; if (valid_cnt - v0 != 1) $display("FAIL after_ferr_valid got %0d want 1", valid_cnt - v0); else n_pass++;
    n_checks++; if (data_out !== 8'h5A) $display("FAIL after_ferr_data got %h want 5a", data_out); else n_pass++;
    n_checks++; if (ferr_cnt - f0 != 1) $display("FAIL after_ferr_ferr got %0d want 1", ferr_cnt - f0); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int v0, sc;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, 1'b0, sc);
    send_frame(8'hFF, 1'b1, 1'b0, sc);
    idle(2 * CPB);
    n_checks++; if (valid_cnt - v0 != 2) $display("FAIL b2b_pulses got %0d want 2", valid_cnt - v0); else n_pass++;
    if (rx_q.size() >= v0 + 2) begin
      n_checks++; if (rx_q[v0] !== 8'h00) $display("FAIL b2b_first got %h want 00", rx_q[v0]); else n_pass++;
      n_checks++; if (rx_q[v0 + 1] !== 8'hFF) $display("FAIL b2b_second got %h want ff", rx_q[v0 + 1]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, sc;
    v0 = valid_cnt; f0 = ferr_cnt;
    // Start bit plus three data bits of 0x81, then abort.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    n_checks++; if (busy !== 1'b1) $display("FAIL midframe_busy got %b want 1", busy); else n_pass++;
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (data_out !== 8'h00) $display("FAIL midreset_data_out got %h want 00", data_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else n_pass++;
    idle(3 * CPB);
    n_checks++; if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0)
      $display("FAIL aborted_strobes got valid=%0d ferr=%0d want 0/0", valid_cnt - v0, ferr_cnt - f0); else n_pass++;
    send_frame(8'h42, 1'b1, 1'b0, sc);
    idle(2 * CPB);
    n_checks++; if (valid_cnt - v0 != 1) $display("FAIL post_reset_valid got %0d want 1", valid_cnt - v0); else n_pass++;
    n_checks++; if (data_out !== 8'h42) $display("FAIL post_reset_data got %h want 42", data_out); else n_pass++;
  endtask

`ifdef USART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0, vp0, sc;
    v0 = valid_cnt; p0 = perr_cnt; vp0 = vp_cnt;
    // 0x07 has three ones, so the correct even-parity bit is 1; send 0.
    send_frame(8'h07, 1'b1, 1'b1, sc);
    idle(2 * CPB);
    n_checks++; if (valid_cnt - v0 != 1) $display("FAIL par_valid got %0d want 1", valid_cnt - v0); else n_pass++;
    n_checks++; if (perr_cnt - p0 != 1) $display("FAIL par_err got %0d want 1", perr_cnt - p0); else n_pass++;
    n_checks++; if (vp_cnt - vp0 != 1) $display("FAIL par_coincident got %0d want 1", vp_cnt - vp0); else n_pass++;
    n_checks++; if (data_out !== 8'h07) $display("FAIL par_data got %h want 07", data_out); else n_pass++;
  endtask
`endif

  task automatic test_global;
    n_checks++; if (overlap_cnt != 0) $display("FAIL strobe_overlap got %0d want 0", overlap_cnt); else n_pass++;
    n_checks++; if (perr_cnt != PB) $display("FAIL parity_total got %0d want %0d", perr_cnt, PB); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_good_frame;
    test_glitch;
    test_frame_error;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef USART_RX_PARITY_EN
    test_parity;
`endif
    test_global;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
